// File: rtl/secret_unpacker_pkg.sv
// Shared definitions for the secret-vector unpacker and the ciphertext path:
// state encoding, lane geometry and the sign-magnitude to mod-2^LOGQ conversion.
package secret_unpacker_pkg;

  localparam int LOGQ_DEF         = 13;
  localparam int LANE_W           = 16;
  localparam int SAMPLES_PER_WORD = 16;
  localparam int LANES_PER_WORD   = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_EMIT0 = 3'd3;
  localparam logic [2:0] ST_EMIT1 = 3'd4;
  localparam logic [2:0] ST_EMIT2 = 3'd5;
  localparam logic [2:0] ST_EMIT3 = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // LATCH..EMIT3 are consecutive so the emit sequence can simply count up.
  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    LATCH = ST_LATCH,
    EMIT0 = ST_EMIT0,
    EMIT1 = ST_EMIT1,
    EMIT2 = ST_EMIT2,
    EMIT3 = ST_EMIT3,
    DONE  = ST_DONE
  } state_t;

  // Converts one 4-bit sign-magnitude sample into a zero-padded lane holding
  // the value mod 2^logq. Negative zero lands on 0; magnitudes 5..7 pass
  // through the same formula unflagged.
  function automatic logic [LANE_W-1:0] sm4_to_modq_lane(input logic [3:0] sample,
                                                         input int logq);
    logic [LANE_W-1:0] mag;
    logic [LANE_W-1:0] mask;
    mag  = LANE_W'(sample[2:0]);
    mask = (LANE_W'(1) << logq) - LANE_W'(1);
    return sample[3] ? ((LANE_W'(0) - mag) & mask) : mag;
  endfunction

endpackage

// File: rtl/secret_unpacker_sm4_to_modq.sv
// Combinational converter: four packed 4-bit samples into four 16-bit lanes.
module sm4_to_modq
  import secret_unpacker_pkg::*;
#(
  parameter int LOGQ = LOGQ_DEF
) (
  input  logic [15:0] samples,
  output logic [63:0] lanes
);

  // Convert each sample into its lane.
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    lanes = '0;
    for (int i = 0; i < LANES_PER_WORD; i++) begin
      lanes[LANE_W*i +: LANE_W] = sm4_to_modq_lane(samples[4*i +: 4], LOGQ);
    end
  end

endmodule

// File: rtl/secret_unpacker.sv
// secret_unpacker: reads packed sign-magnitude secret words from the sampler
// region and writes each one out as four 64-bit words of four mod-2^LOGQ lanes.
// Optional feature: define SECRET_UNPACK_WIPE_EN to add src_wen, which zeroes
// each source word in EMIT0 so raw samples do not persist.
module secret_unpacker
  import secret_unpacker_pkg::*;
#(
  parameter int         NUM_WORDS = 48,
  parameter logic [8:0] SRC_BASE  = 9'd0,
  parameter logic [8:0] DST_BASE  = 9'd0,
  parameter int         LOGQ      = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [8:0]  rd_address,
  input  logic [63:0] data_in,
  output logic [8:0]  wt_address,
  output logic [63:0] data_out,
  output logic        wen,
  output logic        done
`ifdef SECRET_UNPACK_WIPE_EN
  ,
  output logic        src_wen
`endif
);

  state_t      state;
  logic [15:0] j;
  logic [8:0]  wr_ptr;
  logic [63:0] hold;
  logic [1:0]  k_next;
  logic [15:0] slice;
  logic [63:0] lane_word;

  // Pick the 16-bit slice for the word that will be visible next cycle; in
  // LATCH the hold register is still being loaded, so slice 0 comes straight
  // from the BRAM output.
  always_comb begin
    k_next = 2'd0;
    case (state)
      EMIT0:   k_next = 2'd1;
      EMIT1:   k_next = 2'd2;
      EMIT2:   k_next = 2'd3;
      default: k_next = 2'd0;
    endcase
    slice = (state == LATCH) ? data_in[15:0] : hold[{k_next, 4'b0000} +: 16];
  end

  sm4_to_modq #(.LOGQ(LOGQ)) u_conv (
    .samples(slice),
    .lanes  (lane_word)
  );

  // Control FSM with registered outputs; write outputs are set one edge ahead
  // so wen is high exactly while the FSM sits in EMIT0..EMIT3.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the reset is
    // synchronous, so it is just the highest-priority branch of the clocked block.
    if (rst) begin
      state      <= IDLE;
      j          <= '0;
      rd_address <= SRC_BASE;
      wt_address <= DST_BASE;
      wr_ptr     <= DST_BASE;
      hold       <= '0;
      data_out   <= '0;
      wen        <= 1'b0;
      done       <= 1'b0;
`ifdef SECRET_UNPACK_WIPE_EN
      src_wen    <= 1'b0;
`endif
    end else begin
      wen <= 1'b0;
`ifdef SECRET_UNPACK_WIPE_EN
      src_wen <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= READ;
            j          <= '0;
            rd_address <= SRC_BASE;
            wr_ptr     <= DST_BASE;
            done       <= 1'b0;
          end
        end
        READ: state <= LATCH;
        LATCH, EMIT0, EMIT1, EMIT2: begin
          if (state == LATCH) begin
            hold <= data_in;
`ifdef SECRET_UNPACK_WIPE_EN
            src_wen <= 1'b1;
`endif
          end
          wen        <= 1'b1;
          data_out   <= lane_word;
          wt_address <= wr_ptr;
          wr_ptr     <= wr_ptr + 9'd1;
          state      <= state_t'(state + 3'd1);
        end
        EMIT3: begin
          if (j == 16'(NUM_WORDS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= READ;
            j          <= j + 16'd1;
            rd_address <= SRC_BASE + 9'(j + 16'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secret_unpacker.sv
// Self-checking bench for secret_unpacker: two instances (defaults, and a
// small wrapping configuration), BRAM models, and a write scoreboard fed by
// a behavioural model of the conversion.
module tb_secret_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic [8:0]  rd_address_a, wt_address_a, rd_address_b, wt_address_b;
  logic [63:0] data_in_a, data_out_a, data_in_b, data_out_b;
  logic        wen_a, done_a, wen_b, done_b;
`ifdef SECRET_UNPACK_WIPE_EN
  logic        src_wen_a, src_wen_b;
`endif

  secret_unpacker dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rd_address(rd_address_a),
    .data_in(data_in_a), .wt_address(wt_address_a), .data_out(data_out_a),
    .wen(wen_a), .done(done_a)
`ifdef SECRET_UNPACK_WIPE_EN
    , .src_wen(src_wen_a)
`endif
  );

  secret_unpacker #(.NUM_WORDS(4), .SRC_BASE(9'd10), .DST_BASE(9'd500), .LOGQ(13)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rd_address(rd_address_b),
    .data_in(data_in_b), .wt_address(wt_address_b), .data_out(data_out_b),
    .wen(wen_b), .done(done_b)
`ifdef SECRET_UNPACK_WIPE_EN
    , .src_wen(src_wen_b)
`endif
  );

  // Source BRAMs: one-cycle read latency, optional zeroing writes.
  logic [63:0] mem [2][512];
  always @(posedge clk) begin
    data_in_a <= mem[0][rd_address_a];
    data_in_b <= mem[1][rd_address_b];
`ifdef SECRET_UNPACK_WIPE_EN
    if (src_wen_a) mem[0][rd_address_a] <= 64'h0;
    if (src_wen_b) mem[1][rd_address_b] <= 64'h0;
`endif
  end

  typedef struct {
    logic [8:0]  addr;
    logic [63:0] data;
  } wr_t;
  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t e_a, e_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc;
  int wen_cnt_a, wen_cnt_b, swen_cnt_a, swen_cnt_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Behavioural model: signed value of the sample, reduced mod 2^13.
  function automatic int model_coef(input logic [3:0] s);
    int mag;
    mag = int'(s[2:0]);
    return s[3] ? (8192 - mag) % 8192 : mag;
  endfunction

  function automatic logic [63:0] model_word(input logic [15:0] four);
    logic [63:0] w;
    for (int i = 0; i < 4; i++) w[16*i +: 16] = 16'(model_coef(four[4*i +: 4]));
    return w;
  endfunction

  // Queue up every destination write a run must produce, in order.
  task automatic plan(input int which, input int nwords, input int src, input int dst);
    wr_t w;
    logic [63:0] word;
    for (int j = 0; j < nwords; j++) begin
      word = mem[which][(src + j) % 512];
      for (int k = 0; k < 4; k++) begin
        w.addr = 9'((dst + 4 * j + k) % 512);
        w.data = model_word(word[16*k +: 16]);
        if (which == 0) exp_a.push_back(w);
        else            exp_b.push_back(w);
      end
    end
  endtask

  // Scoreboard: every write must match the next planned write.
  always @(negedge clk) begin
    if (wen_a === 1'b1) begin
      wen_cnt_a++;
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_write got=%h want=none", wt_address_a);
      end else begin
        e_a = exp_a.pop_front();
        check("a_wt_address", 64'(wt_address_a), 64'(e_a.addr));
        check("a_data_out", data_out_a, e_a.data);
      end
    end
    if (wen_b === 1'b1) begin
      wen_cnt_b++;
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_write got=%h want=none", wt_address_b);
      end else begin
        e_b = exp_b.pop_front();
        check("b_wt_address", 64'(wt_address_b), 64'(e_b.addr));
        check("b_data_out", data_out_b, e_b.data);
      end
    end
`ifdef SECRET_UNPACK_WIPE_EN
    if (src_wen_a === 1'b1) swen_cnt_a++;
    if (src_wen_b === 1'b1) swen_cnt_b++;
`endif
  end

  task automatic go(input int which);
    @(posedge clk); #1;
    if (which == 0) begin start_a = 1'b1; wen_cnt_a = 0; swen_cnt_a = 0; end
    else            begin start_b = 1'b1; wen_cnt_b = 0; swen_cnt_b = 0; end
    start_cyc = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    check(which == 0 ? "a_done_drop" : "b_done_drop",
          64'(which == 0 ? done_a : done_b), 64'h0);
  endtask

  task automatic wait_done(input int which, input int lat, input int wens);
    int n = 0;
    while ((which == 0 ? done_a : done_b) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL done_timeout got=0 want=1 (dut %0d)", which);
    end else begin
      check("done_latency", 64'(cyc - start_cyc), 64'(lat));
    end
    check("wen_count", 64'(which == 0 ? wen_cnt_a : wen_cnt_b), 64'(wens));
    check("writes_left", 64'(which == 0 ? exp_a.size() : exp_b.size()), 64'h0);
`ifdef SECRET_UNPACK_WIPE_EN
    check("src_wen_count", 64'(which == 0 ? swen_cnt_a : swen_cnt_b), 64'(wens / 4));
`endif
  endtask

  task automatic fill_pattern();
    for (int j = 0; j < 512; j++) mem[0][j] = {16{4'(j)}};
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    fill_pattern();
    for (int j = 0; j < 512; j++) mem[1][j] = 64'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wen", 64'(wen_a), 64'h0);
    check("rst_done", 64'(done_a), 64'h0);
    check("rst_rd_address", 64'(rd_address_a), 64'h0);
    check("rst_wt_address", 64'(wt_address_a), 64'h0);
    check("rst_data_out", data_out_a, 64'h0);
    check("rst_b_rd_address", 64'(rd_address_b), 64'd10);
    check("rst_b_wt_address", 64'(wt_address_b), 64'd500);

    // Pin the model to hand-computed values.
    check("model_c41a", model_word(16'hC41A), 64'h1FFC_0004_0001_1FFE);
    check("model_neg_zero", model_word(16'h8888), 64'h0);
    check("model_minus7", 64'(model_coef(4'hF)), 64'h1FF9);

    // Run 1: the C41A word, then a word of negative zeros, then pattern.
    mem[0][0] = 64'h0000_0000_0000_C41A;
    mem[0][1] = {16{4'h8}};
    plan(0, 48, 0, 0);
    go(0);
    begin
      int n = 0;
      while (wen_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("first_write_data", data_out_a, 64'h1FFC_0004_0001_1FFE);
      check("first_write_addr", 64'(wt_address_a), 64'h0);
      for (int k = 1; k < 8; k++) begin
        @(negedge clk);
        if (k == 4 || k == 5) continue;  // READ/LATCH of word 1
        check("zero_write_data", data_out_a, 64'h0);
      end
    end
    wait_done(0, 289, 192);
`ifdef SECRET_UNPACK_WIPE_EN
    for (int j = 0; j < 48; j++) check("wiped", mem[0][j], 64'h0);
`endif

    // Run 2: restart from DONE, reset during EMIT2 of word 5.
    fill_pattern();
    plan(0, 48, 0, 0);
    go(0);
    repeat (34) @(posedge clk);
    #1;
    check("emit2_w5_wen", 64'(wen_a), 64'h1);
    check("emit2_w5_addr", 64'(wt_address_a), 64'd22);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete();
    check("midrst_wen", 64'(wen_a), 64'h0);
    check("midrst_rd_address", 64'(rd_address_a), 64'h0);
    check("midrst_done", 64'(done_a), 64'h0);
    check("midrst_wt_address", 64'(wt_address_a), 64'h0);
    repeat (10) @(posedge clk);
    plan(0, 48, 0, 0);
    go(0);
    wait_done(0, 289, 192);

    // Run 3: small config wrapping past address 511, spurious start mid-run.
    mem[1][10] = 64'h0123_4567_89AB_CDEF;
    mem[1][11] = 64'hFEDC_BA98_7654_3210;
    mem[1][12] = 64'h8888_0000_CCCC_4444;
    mem[1][13] = 64'hF7E6_D5C4_B3A2_9180;
    plan(1, 4, 10, 500);
    check("plan_b_first_addr", 64'(exp_b[0].addr), 64'd500);
    check("plan_b_last_addr", 64'(exp_b[15].addr), 64'd3);
    go(1);
    repeat (7) @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    wait_done(1, 25, 16);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/secret_unpacker.md
# secret_unpacker

Converts the packed secret-vector samples produced by the binomial sampler into coefficient lanes that the polynomial multiplier can consume directly. Each source BRAM word holds 16 four-bit sign-magnitude samples. The block turns each sample into a 13-bit coefficient mod 2^13 and writes it as four 64-bit destination words of four 16-bit lanes each. It sits between the sampler's output region and the multiplier's secret-operand region, driven by a start/done handshake from the coprocessor controller.

## Interface
- `NUM_WORDS`, default 48: source words to process (3 polynomials × 16 words).
- `SRC_BASE`, default 9'd0: first source BRAM address.
- `DST_BASE`, default 9'd0: first destination BRAM address.
- `LOGQ`, default 13: coefficient width; lanes are 16 bits.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: one-cycle pulse, begins a run; sampled only in IDLE or DONE.
- `rd_address` out 9: source BRAM read address.
- `data_in` in 64: source word, valid one cycle after `rd_address`.
- `wt_address` out 9: destination BRAM write address.
- `data_out` out 64: destination word, four 16-bit lanes.
- `wen` out 1: destination write enable.
- `done` out 1: run complete.

## Operation
- Sample m of a source word is `data_in[4m+3:4m]`: bit 3 is the sign, bits 2:0 are the magnitude (0..4).
- Coefficient conversion:
  - `coef = sign ? (2^13 − mag) mod 2^13 : mag`.
  - Negative zero (4'h8) maps to 0.
  - Magnitudes 5..7 are converted by the same formula and are not flagged.
- Output word k (0..3) of source word j:
  - lane i at `data_out[16i+15:16i]` = `{3'b0, coef(sample 4k+i)}`.
  - Written to `DST_BASE + 4j + k`.
- States:
  - IDLE → READ on `start`.
  - READ: drive `rd_address = SRC_BASE + j`.
  - LATCH: capture `data_in` into the 64-bit hold register.
  - EMIT0..EMIT3: `wen` = 1, write output word k. EMIT3 → READ with j+1, or → DONE when j = NUM_WORDS−1.
  - DONE: hold; `start` → READ with j = 0.
- Both address counters are 9-bit and wrap modulo 512 with no error.
- `start` asserted during READ..EMIT3 is ignored.

## Timing
- Reset values:
  - state IDLE, j = 0.
  - `rd_address` = SRC_BASE, `wt_address` = DST_BASE.
  - `wen` = 0, `data_out` = 0, `done` = 0.
- `rst` mid-run: next cycle is IDLE with all reset values; any partial output is abandoned and no further writes occur.
- Per source word: 6 cycles (READ, LATCH, 4× EMIT).
- Full run: 6·NUM_WORDS cycles from the first READ. With the defaults, `done` rises 289 cycles after the `start` cycle.
- `wen`, `wt_address` and `data_out` are registered and change together; `wen` is high for exactly 4·NUM_WORDS cycles per run.
- `done` is high in DONE only and drops the cycle after an accepted `start`.

## Configuration
- `SECRET_UNPACK_WIPE_EN` defined:
  - Adds output `src_wen` (1 bit).
  - In EMIT0 the block asserts `src_wen` to write 64'h0 to the source BRAM at the current `rd_address`, so raw samples do not persist.
  - `src_wen` resets to 0.
- Not defined: no `src_wen` port; the source region is never written.

## Structure
- Shared package holds:
  - State encoding localparams.
  - `LOGQ`, lane width 16, samples per word 16, lanes per output word 4.
  - The sign-magnitude-to-mod-q conversion function, reused by the ciphertext path.
- One sub-module, `sm4_to_modq`: combinational, converts 4 samples to a 64-bit lane word. Instantiated once and fed by a 16-bit slice of the hold register selected by k.

## Test plan
- Source word 0 = 64'h0000_0000_0000_C41A, `start` → first write at DST_BASE with `data_out` = 64'h1FFC_0004_0001_1FFE; the next three writes are 64'h0.
- Word of all 4'h8 → four writes of 64'h0 (negative zero).
- Default run with source word j = {16{j[3:0]}} → exactly 192 `wen` pulses at addresses 0..191 in order; `done` rises 289 cycles after `start`.
- `rst` asserted during EMIT2 of word 5 → next cycle `wen` = 0, `rd_address` = SRC_BASE, `done` = 0; a new `start` reruns from word 0.
- DST_BASE = 9'd500, NUM_WORDS = 4 → writes go to 500..511 then 0..3 (wrap); `start` pulsed mid-run has no effect.
- With `SECRET_UNPACK_WIPE_EN`: after a full run, every source address SRC_BASE..SRC_BASE+47 reads 64'h0 and `src_wen` pulsed 48 times.
